// File: rtl/unified_mem_responder_if.sv
// Request/response bundle between the CPU's fetch/data ports and the memory responder.
// The CPU side is the master; the responder is the slave.
interface unified_mem_responder_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_ready;
  logic        i_valid;
  logic [31:0] i_rdata;

  logic        d_req;
  logic        d_we;
  logic [3:0]  d_be;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ready;
  logic        d_valid;
  logic [31:0] d_rdata;

  logic        busy;

  modport master (
    output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
    input  i_ready, i_valid, i_rdata, d_ready, d_valid, d_rdata, busy
  );

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata,
    output i_ready, i_valid, i_rdata, d_ready, d_valid, d_rdata, busy
  );
endinterface

// File: rtl/unified_mem_responder.sv
// Single-ported word memory shared by the fetch and data ports, data port first.
// Each accepted access commits LATENCY edges after acceptance and pulses valid for one cycle.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access in flight; arbitrate and accept one request
// ST_WAIT | access latched; cnt_q counts down to the commit edge
module unified_mem_responder #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  unified_mem_responder_if.slave   bus
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  state_e                  state_q, state_d;
  logic                    sel_q, sel_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic                    we_q, we_d;
  logic [3:0]              be_q, be_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    i_valid_q, i_valid_d;
  logic                    d_valid_q, d_valid_d;
  logic [31:0]             i_rdata_q, i_rdata_d;
  logic [31:0]             d_rdata_q, d_rdata_d;

  logic [31:0]             mem [DEPTH];
  logic [31:0]             old_word;
  logic [31:0]             merged_word;
  logic                    commit;
  logic                    mem_we;
  logic                    i_ready_c, d_ready_c;

  // Byte offset and bits above the array size are don't-care; the address wraps.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[31:ADDR_WIDTH+2], bus.i_addr[1:0],
                              bus.d_addr[31:ADDR_WIDTH+2], bus.d_addr[1:0]};

  assign old_word = mem[idx_q];

  always_comb begin
    merged_word = old_word;
    for (int n = 0; n < 4; n++) begin
      if (be_q[n]) merged_word[8*n +: 8] = wdata_q[8*n +: 8];
    end
  end

  assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd0);
  // A commit edge that coincides with reset must leave the array untouched.
  assign mem_we = reset_n && commit && sel_q && we_q && (be_q != 4'b0000);

  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= merged_word;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    d_ready_c = 1'b0;
    i_ready_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        d_ready_c = bus.d_req;
        i_ready_c = bus.i_req & ~bus.d_req;
        if (d_ready_c) begin
          sel_d   = 1'b1;
          idx_d   = bus.d_addr[ADDR_WIDTH+1:2];
          we_d    = bus.d_we;
          be_d    = bus.d_be;
          wdata_d = bus.d_wdata;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end else if (i_ready_c) begin
          sel_d   = 1'b0;
          idx_d   = bus.i_addr[ADDR_WIDTH+1:2];
          we_d    = 1'b0;
          be_d    = 4'b0000;
          wdata_d = 32'h0;
          cnt_d   = CNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_IDLE;
          if (sel_q) begin
            d_valid_d = 1'b1;
            d_rdata_d = we_q ? merged_word : old_word;
          end else begin
            i_valid_d = 1'b1;
            i_rdata_d = old_word;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      sel_q     <= 1'b0;
      idx_q     <= '0;
      we_q      <= 1'b0;
      be_q      <= 4'b0000;
      wdata_q   <= 32'h0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_rdata_q <= 32'h0;
      d_rdata_q <= 32'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign bus.d_ready = reset_n & d_ready_c;
  assign bus.i_ready = reset_n & i_ready_c;
  assign bus.i_valid = i_valid_q;
  assign bus.d_valid = d_valid_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_unified_mem_responder.sv
// Directed bench for unified_mem_responder: reset, store/load, byte lanes,
// arbitration, address wrap, zero byte-enable and reset during an in-flight store.
module tb_unified_mem_responder;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  unified_mem_responder_if bus();

  unified_mem_responder #(.ADDR_WIDTH(10), .LATENCY(LAT)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Drives one data access; returns edges from acceptance to the sample where
  // d_valid is seen (-1 no response, -2 never accepted) and the response word.
  task automatic data_xact(input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata);
    int k;
    bus.d_we = we; bus.d_be = be; bus.d_addr = addr; bus.d_wdata = wdata;
    bus.d_req = 1'b1;
    #1;
    k = 0;
    while (!bus.d_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    rdata = 32'hx;
    if (!bus.d_ready) begin
      bus.d_req = 1'b0;
      lat = -2;
    end else begin
      @(posedge clk); #1;
      bus.d_req = 1'b0;
      lat = 0;
      do begin
        @(posedge clk); #1; lat++;
      end while (!bus.d_valid && lat < 40);
      if (!bus.d_valid) lat = -1;
      rdata = bus.d_rdata;
    end
  endtask

  task automatic fetch_xact(input logic [31:0] addr, output int lat, output logic [31:0] rdata);
    int k;
    bus.i_addr = addr;
    bus.i_req = 1'b1;
    #1;
    k = 0;
    while (!bus.i_ready && k < 50) begin
      @(posedge clk); #1; k++;
    end
    rdata = 32'hx;
    if (!bus.i_ready) begin
      bus.i_req = 1'b0;
      lat = -2;
    end else begin
      @(posedge clk); #1;
      bus.i_req = 1'b0;
      lat = 0;
      do begin
        @(posedge clk); #1; lat++;
      end while (!bus.i_valid && lat < 40);
      if (!bus.i_valid) lat = -1;
      rdata = bus.i_rdata;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.i_req = 1'b1; bus.i_addr = 32'h0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    @(posedge clk); @(posedge clk); #1;
    n_tests++; if (bus.i_ready !== 1'b0) begin n_fail++; $display("FAIL reset_i_ready: got %b want 0", bus.i_ready); end
    n_tests++; if (bus.d_ready !== 1'b0) begin n_fail++; $display("FAIL reset_d_ready: got %b want 0", bus.d_ready); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_tests++; if (bus.i_valid !== 1'b0 || bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valids: got i=%b d=%b want 0 0", bus.i_valid, bus.d_valid); end
    n_tests++; if (bus.i_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_i_rdata: got %h want 00000000", bus.i_rdata); end
    n_tests++; if (bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_d_rdata: got %h want 00000000", bus.d_rdata); end
    bus.i_req = 1'b0; bus.d_req = 1'b0;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_store_load();
    int lat; logic [31:0] rd;
    data_xact(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, lat, rd);
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL store_latency: got %0d want %0d", lat, LAT); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL store_ack_data: got %h want deadbeef", rd); end
    n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_at_valid: got %b want 0", bus.busy); end
    @(posedge clk); #1;
    n_tests++; if (bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL d_valid_one_cycle: got %b want 0", bus.d_valid); end
    data_xact(1'b0, 4'h0, 32'h10, 32'h0, lat, rd);
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL load_latency: got %0d want %0d", lat, LAT); end
    n_tests++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_byte_lanes();
    int lat; logic [31:0] rd;
    data_xact(1'b1, 4'b0100, 32'h10, 32'h00AA0000, lat, rd);
    n_tests++; if (rd !== 32'hDEAABEEF) begin n_fail++; $display("FAIL lane2_merge: got %h want deaabeef", rd); end
    fetch_xact(32'h12, lat, rd);
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL fetch_latency: got %0d want %0d", lat, LAT); end
    n_tests++; if (rd !== 32'hDEAABEEF) begin n_fail++; $display("FAIL fetch_lane_data: got %h want deaabeef", rd); end
    n_tests++; if (bus.d_rdata !== 32'hDEAABEEF) begin n_fail++; $display("FAIL d_rdata_hold: got %h want deaabeef", bus.d_rdata); end
    data_xact(1'b1, 4'b1001, 32'h10, 32'h11000022, lat, rd);
    n_tests++; if (rd !== 32'h11AABE22) begin n_fail++; $display("FAIL lane03_merge: got %h want 11aabe22", rd); end
    data_xact(1'b0, 4'h0, 32'h13, 32'h0, lat, rd);
    n_tests++; if (rd !== 32'h11AABE22) begin n_fail++; $display("FAIL lane03_readback: got %h want 11aabe22", rd); end
  endtask

  task automatic test_priority();
    int dv_k, ir_k, iv_k;
    logic overlap, acc_pending, busy1, iready1;
    logic [31:0] idata;
    dv_k = -1; ir_k = -1; iv_k = -1; overlap = 1'b0; acc_pending = 1'b0;
    busy1 = 1'bx; iready1 = 1'bx; idata = 32'hx;
    bus.i_addr = 32'h10; bus.i_req = 1'b1;
    bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 32'h10; bus.d_req = 1'b1;
    #1;
    n_tests++; if (bus.d_ready !== 1'b1 || bus.i_ready !== 1'b0) begin n_fail++; $display("FAIL prio_ready: got d=%b i=%b want d=1 i=0", bus.d_ready, bus.i_ready); end
    @(posedge clk); #1;   // edge 0: data accepted
    bus.d_req = 1'b0;
    busy1 = bus.busy; iready1 = bus.i_ready;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (acc_pending) begin bus.i_req = 1'b0; acc_pending = 1'b0; end
      if (bus.d_valid && dv_k < 0) dv_k = k;
      if (bus.d_valid && bus.i_ready) overlap = 1'b1;
      if (bus.i_ready && ir_k < 0) begin acc_pending = 1'b1; ir_k = k; end
      if (bus.i_valid) begin iv_k = k; idata = bus.i_rdata; break; end
    end
    bus.i_req = 1'b0;
    n_tests++; if (busy1 !== 1'b1 || iready1 !== 1'b0) begin n_fail++; $display("FAIL prio_wait_holdoff: got busy=%b i_ready=%b want 1 0", busy1, iready1); end
    n_tests++; if (dv_k !== LAT) begin n_fail++; $display("FAIL prio_d_valid_cycle: got %0d want %0d", dv_k, LAT); end
    n_tests++; if (ir_k !== LAT || overlap !== 1'b1) begin n_fail++; $display("FAIL prio_i_ready_with_d_valid: got cycle %0d overlap %b want %0d 1", ir_k, overlap, LAT); end
    // Fetch is accepted at edge LAT+1, so i_valid is seen just after edge 2*LAT+1,
    // i.e. during the cycle that ends at edge 2*(LAT+1).
    n_tests++; if (iv_k !== 2*LAT+1) begin n_fail++; $display("FAIL prio_i_valid_cycle: got %0d want %0d", iv_k, 2*LAT+1); end
    n_tests++; if (idata !== 32'h11AABE22) begin n_fail++; $display("FAIL prio_fetch_data: got %h want 11aabe22", idata); end
    @(posedge clk); #1;
    n_tests++; if (bus.i_valid !== 1'b0) begin n_fail++; $display("FAIL i_valid_one_cycle: got %b want 0", bus.i_valid); end
  endtask

  task automatic test_wrap_be0();
    int lat; logic [31:0] rd;
    data_xact(1'b1, 4'hF, 32'h0000_1004, 32'hCAFEF00D, lat, rd);
    n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wrap_store_ack: got %h want cafef00d", rd); end
    data_xact(1'b0, 4'h0, 32'h0000_0004, 32'h0, lat, rd);
    n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL wrap_alias_load: got %h want cafef00d", rd); end
    data_xact(1'b1, 4'h0, 32'h0000_0004, 32'hFFFFFFFF, lat, rd);
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL be0_valid_latency: got %0d want %0d", lat, LAT); end
    n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL be0_ack_old_word: got %h want cafef00d", rd); end
    data_xact(1'b0, 4'h0, 32'h0000_0004, 32'h0, lat, rd);
    n_tests++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL be0_mem_unchanged: got %h want cafef00d", rd); end
    n_tests++; if (bus.i_rdata !== 32'h11AABE22) begin n_fail++; $display("FAIL i_rdata_hold: got %h want 11aabe22", bus.i_rdata); end
  endtask

  task automatic test_reset_mid_store();
    int lat; logic [31:0] rd;
    logic dv_at_commit, busy_at_commit;
    data_xact(1'b1, 4'hF, 32'h20, 32'h0, lat, rd);
    bus.d_we = 1'b1; bus.d_be = 4'hF; bus.d_addr = 32'h20; bus.d_wdata = 32'h12345678;
    bus.d_req = 1'b1;
    @(posedge clk); #1;   // acceptance edge E
    bus.d_req = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;   // commit edge E+LAT with reset low
    dv_at_commit = bus.d_valid; busy_at_commit = bus.busy;
    reset_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (dv_at_commit !== 1'b0 || bus.d_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid: got %b/%b want 0/0", dv_at_commit, bus.d_valid); end
    n_tests++; if (busy_at_commit !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b want 0", busy_at_commit); end
    n_tests++; if (bus.d_rdata !== 32'h0) begin n_fail++; $display("FAIL abort_d_rdata: got %h want 00000000", bus.d_rdata); end
    data_xact(1'b0, 4'h0, 32'h20, 32'h0, lat, rd);
    n_tests++; if (lat !== LAT) begin n_fail++; $display("FAIL post_reset_latency: got %0d want %0d", lat, LAT); end
    n_tests++; if (rd !== 32'h0) begin n_fail++; $display("FAIL abort_not_committed: got %h want 00000000", rd); end
  endtask

  initial begin
    bus.i_req = 1'b0; bus.i_addr = 32'h0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_be = 4'h0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
    test_reset();
    test_store_load();
    test_byte_lanes();
    test_priority();
    test_wrap_be0();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/unified_mem_responder.md
# unified_mem_responder

Memory-side responder for the pipelined CPU's instruction-fetch and data-access ports. It owns a single-ported 32-bit word array and arbitrates between the IF-stage fetch port and the Mem-stage load/store port, data port winning. Each accepted request is served with a fixed programmable latency, using a req/ready acceptance handshake and a one-cycle valid response. Stores apply byte enables so lane-selected stores commit in place; the CPU's pipeline keep/stall logic consumes `busy` and the ready/valid pairs.

## Interface
- ADDR_WIDTH, 10, word-address bits; depth = 2^ADDR_WIDTH words.
- LATENCY, 2, cycles from acceptance edge to commit edge; legal range 1..15.
- clk  input  1  clock; all state changes on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- i_req  input  1  fetch request; held high with stable i_addr until accepted.
- i_addr  input  32  fetch byte address.
- i_ready  output  1  fetch accepted at this edge (combinational).
- i_valid  output  1  one-cycle pulse: i_rdata holds the fetched word.
- i_rdata  output  32  fetched word; holds until the next fetch response.
- d_req  input  1  data request; held high with stable d_* until accepted.
- d_we  input  1  1 = store, 0 = load.
- d_be  input  4  byte enables for stores; bit n = bits [8n+7:8n].
- d_addr  input  32  data byte address.
- d_wdata  input  32  store data, already lane-aligned.
- d_ready  output  1  data request accepted at this edge (combinational).
- d_valid  output  1  one-cycle pulse: load data or store acknowledge.
- d_rdata  output  32  loaded word, or the merged word after a store; holds until the next data response.
- busy  output  1  high whenever state is not IDLE.

## Operation
- Word index = addr[ADDR_WIDTH+1:2]; addr[1:0] and bits above ADDR_WIDTH+1 are ignored, so the address wraps modulo depth.
- States are IDLE and WAIT. Internal registers: sel (0 = I, 1 = D), latched address, we, be, wdata, and a 4-bit cnt.
- In IDLE:
  - d_ready = d_req.
  - i_ready = i_req & ~d_req. The data port has fixed priority.
  - At most one ready is high in any cycle.
- Acceptance edge (req & ready in IDLE): latch the request, cnt <= LATENCY-1, state <= WAIT.
- In WAIT, cnt decrements each edge. At the edge where cnt == 0 (the commit edge):
  - Load or fetch: read mem[idx] into the selected port's rdata register.
  - Store: for each n with be[n]=1, mem[idx] byte n <= wdata byte n. d_rdata <= the merged word, meaning new bytes where be=1 and old bytes elsewhere.
  - Store with be = 4'b0000: memory is unchanged, d_rdata <= old word, d_valid still pulses.
  - Set the selected port's valid for exactly the next cycle. state <= IDLE.
- Both ready outputs are 0 in WAIT. Requests arriving during WAIT are held off and arbitrated in the next IDLE cycle.
- Read-after-write: a later read returns the committed merged data; no bypass is needed because accesses are serialized.
- The array is not reset; its contents after reset are undefined to the bench, which must write before reading.

## Timing
- Reset values (reset_n = 0 at an edge): state IDLE, cnt 0, i_valid 0, d_valid 0, i_rdata 0, d_rdata 0, busy 0. Ready outputs are 0 while reset_n is low.
- Reset in WAIT aborts the access. A store whose commit edge coincides with a low reset_n is NOT committed, and no valid pulse follows.
- Latency for a request accepted at edge E:
  - The commit edge is E+LATENCY.
  - valid is high in the cycle after E+LATENCY.
  - The next request can be accepted at edge E+LATENCY+1.
  - Service interval = LATENCY+1 cycles.
- The valid pulse and the next acceptance can coincide: in the cycle after commit, state is IDLE, so ready may be high while valid is high.
- Simultaneous i_req and d_req in IDLE: data is accepted; fetch is accepted at the first IDLE cycle after the data response.
- Dropping req before acceptance is legal: nothing is latched. Changing addr while req is high and not yet accepted is legal; the value present at the acceptance edge is used.

## Test plan
- Reset: hold reset_n=0 for 2 cycles with i_req=1 -> i_ready=0, busy=0, valids=0, rdatas=0.
- Store then load, LATENCY=2:
  - Store d_addr=0x10, wdata=0xDEADBEEF, be=4'hF, accepted at edge 0 -> d_valid high after edge 2, d_rdata=0xDEADBEEF.
  - Load 0x10, accepted at edge 3 -> d_valid after edge 5, d_rdata=0xDEADBEEF.
- Byte lanes: with 0x10 holding 0xDEADBEEF, store wdata=0x00AA0000, be=4'b0100 -> ack d_rdata=0xDEAABEEF; a subsequent fetch at i_addr=0x12 returns 0xDEAABEEF.
- Priority: i_req and d_req both high in IDLE -> d_ready=1, i_ready=0. i_ready rises in the cycle d_valid pulses. i_valid occurs 2·(LATENCY+1) cycles after the first acceptance edge.
- Reset mid-store: accept a store of 0x12345678 to 0x20 (old 0x0), drive reset_n low at the commit edge -> no d_valid. A later load of 0x20 returns 0x0.
- Wrap and be=0: with ADDR_WIDTH=10, store to 0x1004 -> lands at 0x0004. A store with be=0 -> d_valid pulses and memory is unchanged.
